status_pack: RTL

- Transmit-side counterpart to the command depacker.
- On a `send` request, snapshots the current RF/status fields and builds a fixed 16-byte status frame: header 0xEB 0x90, payload, 8-bit additive checksum.
- Shifts the frame out MSB-first as SPI master (mode 0) on a dedicated return link to the host controller.

---
 rtl/status_pack_pkg.sv | 25 ++
 rtl/spi_master_tx_byte.sv | 71 +++++++
 rtl/status_pack.sv | 117 +++++++++++
 3 files changed

// File: rtl/status_pack_pkg.sv
// status_pack_pkg: status frame constants, byte offsets and FSM encoding shared by status_pack and depack.
package status_pack_pkg;
  localparam logic [7:0] FRAME_HDR0 = 8'hEB;
  localparam logic [7:0] FRAME_HDR1 = 8'h90;
  localparam int STATUS_FRAME_LEN = 16;
  localparam int OFS_HDR0 = 0;
  localparam int OFS_HDR1 = 1;
  localparam int OFS_MODE = 2;
  localparam int OFS_TX_ATT = 3;
  localparam int OFS_RX1_ATT = 4;
  localparam int OFS_RX2_ATT = 5;
  localparam int OFS_RX3_ATT = 6;
  localparam int OFS_PWR = 7;
  localparam int OFS_FLAGS = 8;
  localparam int OFS_TEMP_HI = 9;
  localparam int OFS_TEMP_LO = 10;
  localparam int OFS_FCNT_HI = 11;
  localparam int OFS_FCNT_LO = 12;
  localparam int OFS_ERR_CNT = 13;
  localparam int OFS_RSVD = 14;
  localparam int OFS_CSUM = 15;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SUM, S_CS_SETUP, S_SHIFT, S_NEXT, S_CS_HOLD, S_DONE
  } state_e;
endpackage

// File: rtl/spi_master_tx_byte.sv
// spi_master_tx_byte: shifts one byte MSB-first as SPI mode 0, CLK_DIV clk cycles per sclk half-period.
module spi_master_tx_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       sclk,
  output logic       dout,
  output logic       done
);
  logic active_q, active_d, phase_q, phase_d, sclk_q, sclk_d, dout_q, dout_d, tick;
  logic [7:0] div_q, div_d, sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  assign tick = div_q == 8'(CLK_DIV - 1);
  // done marks the last active cycle so the parent can chain the next byte without a gap
  assign done = active_q && phase_q && tick && bit_q == 3'd7;
  assign sclk = sclk_q;
  assign dout = dout_q;
  always_comb begin
    active_d = active_q;
    phase_d = phase_q;
    sclk_d = sclk_q;
    dout_d = dout_q;
    div_d = div_q;
    sh_d = sh_q;
    bit_d = bit_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        phase_d = 1'b0;
        sclk_d = 1'b0;
        div_d = '0;
        bit_d = '0;
        sh_d = data;
        dout_d = data[7];
      end
    end else if (!tick) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = '0;
      phase_d = !phase_q;
      sclk_d = !phase_q;
      if (phase_q) begin
        bit_d = bit_q + 3'd1;
        sh_d = {sh_q[6:0], 1'b0};
        dout_d = bit_q == 3'd7 ? 1'b0 : sh_q[6];
        active_d = bit_q != 3'd7;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active_q <= 1'b0;
      phase_q <= 1'b0;
      sclk_q <= 1'b0;
      dout_q <= 1'b0;
      div_q <= '0;
      sh_q <= '0;
      bit_q <= '0;
    end else begin
      active_q <= active_d;
      phase_q <= phase_d;
      sclk_q <= sclk_d;
      dout_q <= dout_d;
      div_q <= div_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
    end
endmodule

// File: rtl/status_pack.sv
// status_pack: snapshots RF/status fields into a 16-byte checksummed frame and sends it as SPI mode-0 master.
// Define STATUS_PACK_FRAME_CNT_EN to carry the running frame counter in bytes 11..12 (zero otherwise).
module status_pack
  import status_pack_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [2:0]  mode,
  input  logic        rf_switch,
  input  logic [7:0]  tx_att,
  input  logic [2:0]  rx_ch_pwr_ctrl,
  input  logic [7:0]  rx_ch1_att,
  input  logic [7:0]  rx_ch2_att,
  input  logic [7:0]  rx_ch3_att,
  input  logic [7:0]  status_flags,
  input  logic [15:0] temperature,
  input  logic        crc_err_pulse,
  output logic        busy,
  output logic        frame_done,
  output logic        spi_sclk,
  output logic        spi_dout,
  output logic        spi_cs_n
);
  state_e state_q, state_d;
  logic [7:0] fbuf_q [STATUS_FRAME_LEN];
  logic [7:0] acc_q, acc_d, err_q, err_d, cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [15:0] fcnt;
  logic cs_n_q, busy_q, done_q, cnt_end, byte_start, byte_done;
  assign cnt_end = cnt_q == 8'(CLK_DIV - 1);
  assign byte_start = (state_q == S_CS_SETUP && cnt_end) || state_q == S_NEXT;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     state_d = send ? S_LOAD : S_IDLE;
      S_LOAD:     state_d = S_SUM;
      S_SUM:      state_d = idx_q == 4'd14 ? S_CS_SETUP : S_SUM;
      S_CS_SETUP: state_d = cnt_end ? S_SHIFT : S_CS_SETUP;
      S_SHIFT:    state_d = !byte_done ? S_SHIFT : idx_q == 4'd15 ? S_CS_HOLD : S_NEXT;
      S_NEXT:     state_d = S_SHIFT;
      S_CS_HOLD:  state_d = cnt_end ? S_DONE : S_CS_HOLD;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end
  assign idx_d = state_q == S_LOAD || (state_q == S_SUM && idx_q == 4'd14) ? '0 :
                 state_q == S_SUM || (state_q == S_SHIFT && byte_done) ? idx_q + 4'd1 : idx_q;
  assign acc_d = state_q == S_LOAD ? '0 : state_q == S_SUM ? acc_q + fbuf_q[idx_q] : acc_q;
  assign cnt_d = (state_q == S_CS_SETUP || state_q == S_CS_HOLD) && !cnt_end ? cnt_q + 8'd1 : '0;
  // the clear in LOAD must not swallow a strobe arriving in that same cycle
  assign err_d = state_q == S_LOAD ? {7'd0, crc_err_pulse} :
                 crc_err_pulse && err_q != 8'hFF ? err_q + 8'd1 : err_q;
`ifdef STATUS_PACK_FRAME_CNT_EN
  logic [15:0] fcnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) fcnt_q <= '0;
    else if (state_q == S_DONE) fcnt_q <= fcnt_q + 16'd1;
  assign fcnt = fcnt_q;
`else
  assign fcnt = '0;
`endif
  always_ff @(posedge clk)
    if (state_q == S_LOAD) begin
      fbuf_q[OFS_HDR0] <= FRAME_HDR0;
      fbuf_q[OFS_HDR1] <= FRAME_HDR1;
      fbuf_q[OFS_MODE] <= {4'b0, rf_switch, mode};
      fbuf_q[OFS_TX_ATT] <= tx_att;
      fbuf_q[OFS_RX1_ATT] <= rx_ch1_att;
      fbuf_q[OFS_RX2_ATT] <= rx_ch2_att;
      fbuf_q[OFS_RX3_ATT] <= rx_ch3_att;
      fbuf_q[OFS_PWR] <= {5'b0, rx_ch_pwr_ctrl};
      fbuf_q[OFS_FLAGS] <= status_flags;
      fbuf_q[OFS_TEMP_HI] <= temperature[15:8];
      fbuf_q[OFS_TEMP_LO] <= temperature[7:0];
      fbuf_q[OFS_FCNT_HI] <= fcnt[15:8];
      fbuf_q[OFS_FCNT_LO] <= fcnt[7:0];
      fbuf_q[OFS_ERR_CNT] <= err_q;
      fbuf_q[OFS_RSVD] <= 8'h00;
    end else if (state_q == S_SUM && idx_q == 4'd14) begin
      fbuf_q[OFS_CSUM] <= acc_q + fbuf_q[OFS_RSVD];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cs_n_q <= state_d inside {S_IDLE, S_LOAD, S_SUM, S_DONE};
      busy_q <= !(state_d inside {S_IDLE, S_DONE});
      done_q <= state_d == S_DONE;
    end
  spi_master_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (byte_start),
    .data  (fbuf_q[idx_q]),
    .sclk  (spi_sclk),
    .dout  (spi_dout),
    .done  (byte_done)
  );
  assign spi_cs_n = cs_n_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule
